// File: rtl/ps2_mouse_packet_assembler.sv
// rtl/ps2_mouse_packet_assembler.sv - assembles PS/2 mouse bytes into 3-byte movement packets
module ps2_mouse_packet_assembler #(
    parameter int unsigned TIMEOUT_CYCLES  = 500000,
    parameter bit          SATURATE_OVF    = 1'b1,
    parameter bit          DROP_INIT_BYTES = 1'b1
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] ps2_received_data,
    input  logic       ps2_received_data_en,
    output logic       left_button,
    output logic       right_button,
    output logic       middle_button,
    output logic [8:0] mouse_delta_x,
    output logic [8:0] mouse_delta_y,
    output logic       x_overflow,
    output logic       y_overflow,
    output logic       mouse_data_valid,
    output logic       sync_error
);

    localparam int unsigned           CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_B0 = 2'd0,
        S_B1 = 2'd1,
        S_B2 = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             synced_q, synced_d;
    logic [7:0]       b0_q, b0_d;
    logic [7:0]       b1_q, b1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             publish;
    logic             sync_err_d;
    logic             is_init_byte;
    logic [8:0]       dx_pub, dy_pub;

    // Mouse ACK (0xFA) and self-test-pass (0xAA) bytes are only ignored before the stream is aligned.
    assign is_init_byte = DROP_INIT_BYTES && !synced_q &&
                          ((ps2_received_data == 8'hFA) || (ps2_received_data == 8'hAA));

    // Overflowed axes clamp to the extreme of their sign; otherwise the 9-bit delta is passed through.
    assign dx_pub = (SATURATE_OVF && b0_q[6]) ? (b0_q[4] ? 9'h100 : 9'h0FF)
                                              : {b0_q[4], b1_q};
    assign dy_pub = (SATURATE_OVF && b0_q[7]) ? (b0_q[5] ? 9'h100 : 9'h0FF)
                                              : {b0_q[5], ps2_received_data};

    // State, packet bytes, sync flag and inter-byte timeout counter.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_B0;
            synced_q <= 1'b0;
            b0_q     <= '0;
            b1_q     <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            synced_q <= synced_d;
            b0_q     <= b0_d;
            b1_q     <= b1_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state: byte alignment, packet capture and stall recovery; a strobe beats the timeout.
    always_comb begin
        state_d    = state_q;
        synced_d   = synced_q;
        b0_d       = b0_q;
        b1_d       = b1_q;
        cnt_d      = cnt_q;
        publish    = 1'b0;
        sync_err_d = 1'b0;
        case (state_q)
            S_B0: begin
                cnt_d = '0;
                if (ps2_received_data_en) begin
                    if (!ps2_received_data[3]) begin
                        sync_err_d = 1'b1;
                    end else if (!is_init_byte) begin
                        b0_d    = ps2_received_data;
                        state_d = S_B1;
                    end
                end
            end
            S_B1, S_B2: begin
                if (ps2_received_data_en) begin
                    cnt_d = '0;
                    if (state_q == S_B1) begin
                        b1_d    = ps2_received_data;
                        state_d = S_B2;
                    end else begin
                        state_d  = S_B0;
                        synced_d = 1'b1;
                        publish  = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = S_B0;
                    cnt_d      = '0;
                    sync_err_d = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_B0;
                cnt_d   = '0;
            end
        endcase
    end

    // Packet outputs hold between publishes; valid and sync_error are single-cycle pulses.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            left_button      <= 1'b0;
            right_button     <= 1'b0;
            middle_button    <= 1'b0;
            mouse_delta_x    <= '0;
            mouse_delta_y    <= '0;
            x_overflow       <= 1'b0;
            y_overflow       <= 1'b0;
            mouse_data_valid <= 1'b0;
            sync_error       <= 1'b0;
        end else begin
            mouse_data_valid <= publish;
            sync_error       <= sync_err_d;
            if (publish) begin
                left_button   <= b0_q[0];
                right_button  <= b0_q[1];
                middle_button <= b0_q[2];
                mouse_delta_x <= dx_pub;
                mouse_delta_y <= dy_pub;
                x_overflow    <= b0_q[6];
                y_overflow    <= b0_q[7];
            end
        end
    end

endmodule
